i2c_req_arbiter: RTL and testbench
==================================

# i2c_req_arbiter

Round-robin arbiter and sequencer that shares one I2C master among `NREQ` requester ports. It captures a request, then drives the master's `en`, `read_write`, `slave_addr`, `no_of_bytes` and `data_in` inputs. It tracks the master's ready/busy handshake through one complete transaction and returns read data and ACK status to the winning requester. It sits between the interconnect-side clients and the I2C master.

## Interface
- `NREQ`, 4: number of requester ports (2..8).
- `MAX_BYTES`, 10: maximum bytes per transaction; fixed by the master's data arrays.
- `TIMEOUT`, 1024: cycles allowed for the master to leave ready after `m_en`.
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: per-port request; held with fields stable until `req_ack`.
- `req_rw` in NREQ: 1 = read, 0 = write.
- `req_addr` in NREQ×7: 7-bit slave address.
- `req_nbytes` in NREQ×10: byte count.
- `req_wdata` in NREQ×80: write bytes, 10×8 packed.
- `req_ack` out NREQ: one-cycle pulse when the port's request is captured.
- `done` out NREQ: one-cycle pulse when the port's transaction ends.
- `rsp_rdata` out 80: read data; valid with `done`.
- `rsp_err` out 1: ACK error, length error, or timeout; valid with `done`.
- `m_en` out 1: master start strobe.
- `m_rw` out 1: to master `read_write`.
- `m_addr` out 7: to master `slave_addr`.
- `m_nbytes` out 10: to master `no_of_bytes`.
- `m_wdata` out 80: to master `data_in`.
- `m_ready` in 1: master `busy` output; 1 = master idle and accepting.
- `m_rdata` in 80: master `data_out`.
- `m_ack_error` in 1: master `ack_error`.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- **IDLE:** if any `req_valid` is set, pick a winner by round-robin, searching from pointer `rr` upward with wrap. On that edge:
  - latch the winner's fields into `m_*` registers;
  - pulse `req_ack[winner]`;
  - set `rr = winner+1` (mod NREQ);
  - go to ISSUE.
- **Length check at capture:** if `req_nbytes` is 0 or greater than `MAX_BYTES`, go straight to RESP with `rsp_err=1`. No master transaction is issued.
- **ISSUE:** wait for `m_ready=1`. Then assert `m_en` for exactly one cycle and go to WAIT_START.
- **WAIT_START:** on `m_ready=0`, go to WAIT_DONE. After `TIMEOUT` cycles without it, see Configuration.
- **WAIT_DONE:** while waiting, OR `m_ack_error` into a sticky error flag. On `m_ready=1`, capture `m_rdata` into `rsp_rdata`, set `rsp_err` from the sticky flag, and go to RESP.
- **RESP:** pulse `done[winner]` for one cycle, clear the sticky flag, return to IDLE.
- `m_*` fields stay stable from capture until RESP exits. `rsp_rdata` and `rsp_err` hold until the next RESP.
- Write data is not checked. Read transactions return `m_rdata` unmodified.
- A port whose `req_valid` drops before `req_ack` is not served. A new request from the active port is considered only after RESP.

## Timing
- All outputs are registered.
- Reset values:
  - `req_ack`, `done`, `m_en`, `m_rw` = 0
  - `m_addr`, `m_nbytes`, `m_wdata`, `rsp_rdata` = 0
  - `rsp_err` = 0
  - `rr` = 0, state = IDLE
- `req_valid` seen in IDLE at edge N: `req_ack` is high in cycle N+1. The earliest `m_en` is cycle N+2.
- `done` is asserted exactly 1 cycle after `m_ready` returns high in WAIT_DONE.
- `m_en` is never high for two consecutive cycles, and never high outside ISSUE.
- Simultaneous requests are resolved in a single cycle. The lowest index at or above `rr` wins.
- Reset mid-transaction returns to IDLE at the next edge. Pending `done` is dropped, and `m_en` is 0 in the following cycle.

## Configuration
- `I2C_ARB_TIMEOUT_EN`
  - Defined: an 11-bit watchdog counts cycles in WAIT_START. On reaching `TIMEOUT`, go to RESP with `rsp_err=1` and `rsp_rdata` unchanged.
  - Undefined: no counter; WAIT_START waits indefinitely.

## Test plan
- **Single write:** port 0, addr=0x50, rw=0, nbytes=2, wdata[1:0]=0xA5,0x3C.
  - Model holds `m_ready` low for 40 cycles.
  - Expect: `req_ack[0]` at N+1, one `m_en` pulse with `m_addr`=0x50 and `m_nbytes`=2, then `done[0]` with `rsp_err`=0.
- **Read:** port 2, nbytes=1. Model returns `m_rdata[0]`=0x7E.
  - Expect: `done[2]`, `rsp_rdata[7:0]`=0x7E, `rsp_err`=0.
- **Round-robin fairness:** all four ports held valid continuously.
  - Expect: grant order 0,1,2,3,0 and no port starved.
- **Length errors:** nbytes=0, then nbytes=11.
  - Expect: `req_ack`, then `done` with `rsp_err`=1, and `m_en` never asserted.
- **NACK:** model pulses `m_ack_error` during WAIT_DONE.
  - Expect: `rsp_err`=1 on `done`.
- **Stuck master and reset:** with `I2C_ARB_TIMEOUT_EN` defined and `m_ready` stuck high after `m_en`.
  - Expect: `done` with `rsp_err`=1 after 1024 WAIT_START cycles.
  - Then assert `reset` during WAIT_DONE: all outputs return to 0 next cycle.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master among NREQ requesters and sequences one transaction.
// Optional master-start watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BYTES = 10,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_rw,
    input  logic [NREQ*7-1:0]           req_addr,
    input  logic [NREQ*10-1:0]          req_nbytes,
    input  logic [NREQ*8*MAX_BYTES-1:0] req_wdata,
    output logic [NREQ-1:0]             req_ack,
    output logic [NREQ-1:0]             done,
    output logic [8*MAX_BYTES-1:0]      rsp_rdata,
    output logic                        rsp_err,
    output logic                        m_en,
    output logic                        m_rw,
    output logic [6:0]                  m_addr,
    output logic [9:0]                  m_nbytes,
    output logic [8*MAX_BYTES-1:0]      m_wdata,
    input  logic                        m_ready,
    input  logic [8*MAX_BYTES-1:0]      m_rdata,
    input  logic                        m_ack_error
);
    localparam int DW  = 8 * MAX_BYTES;
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IW + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, act_q, act_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d, done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d, m_wdata_q, m_wdata_d;
    logic            rsp_err_q, rsp_err_d, err_q, err_d;
    logic            m_en_q, m_en_d, m_rw_q, m_rw_d;
    logic [6:0]      m_addr_q, m_addr_d;
    logic [9:0]      m_nbytes_q, m_nbytes_d;

    logic            found, len_bad, wd_expired;
    logic [IW-1:0]   win, win_inc;
    logic [IW1-1:0]  sum, sum_inc;
    logic [9:0]      sel_nbytes;
    logic [NREQ-1:0] win_oh, act_oh;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [10:0] WD_LOAD = 11'(TIMEOUT - 1);
    logic [10:0] wd_q, wd_d;
    assign wd_expired = (wd_q == '0);
`else
    assign wd_expired = 1'b0;
`endif

    // Search upward from rr with wrap; first valid port wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_q} + IW1'(i);
            if (sum >= IW1'(NREQ)) sum = sum - IW1'(NREQ);
            if (!found && req_valid[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
        sum_inc = {1'b0, win} + IW1'(1);
        win_inc = (sum_inc >= IW1'(NREQ)) ? '0 : sum_inc[IW-1:0];
    end

    assign sel_nbytes = req_nbytes[win*10 +: 10];
    assign len_bad    = (sel_nbytes == '0) || (sel_nbytes > 10'(MAX_BYTES));
    assign win_oh     = NREQ'(1) << win;
    assign act_oh     = NREQ'(1) << act_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            act_q      <= '0;
            req_ack_q  <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            rsp_err_q  <= 1'b0;
            err_q      <= 1'b0;
            m_en_q     <= 1'b0;
            m_rw_q     <= 1'b0;
            m_addr_q   <= '0;
            m_nbytes_q <= '0;
            m_wdata_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            act_q      <= act_d;
            req_ack_q  <= req_ack_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            rsp_err_q  <= rsp_err_d;
            err_q      <= err_d;
            m_en_q     <= m_en_d;
            m_rw_q     <= m_rw_d;
            m_addr_q   <= m_addr_d;
            m_nbytes_q <= m_nbytes_d;
            m_wdata_q  <= m_wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (found) state_d = len_bad ? RESP : ISSUE;
            ISSUE:      if (m_en_q) state_d = WAIT_START;
            WAIT_START: begin
                if (!m_ready)       state_d = WAIT_DONE;
                else if (wd_expired) state_d = RESP;
            end
            WAIT_DONE:  if (m_ready) state_d = RESP;
            RESP:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_d       = rr_q;
        act_d      = act_q;
        req_ack_d  = '0;
        done_d     = '0;
        rdata_d    = rdata_q;
        rsp_err_d  = rsp_err_q;
        err_d      = err_q;
        m_en_d     = 1'b0;
        m_rw_d     = m_rw_q;
        m_addr_d   = m_addr_q;
        m_nbytes_d = m_nbytes_q;
        m_wdata_d  = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_d       = wd_q;
`endif
        case (state_q)
            IDLE: if (found) begin
                rr_d       = win_inc;
                act_d      = win;
                req_ack_d  = win_oh;
                m_rw_d     = req_rw[win];
                m_addr_d   = req_addr[win*7 +: 7];
                m_nbytes_d = sel_nbytes;
                m_wdata_d  = req_wdata[win*DW +: DW];
                if (len_bad) begin
                    done_d    = win_oh;
                    rsp_err_d = 1'b1;
                end
            end
            ISSUE: begin
                // m_en is registered, so ISSUE stays one more cycle to cover the strobe.
                m_en_d = m_ready && !m_en_q;
`ifdef I2C_ARB_TIMEOUT_EN
                wd_d   = WD_LOAD;
`endif
            end
            WAIT_START: begin
                if (m_ready && wd_expired) begin
                    done_d    = act_oh;
                    rsp_err_d = 1'b1;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (m_ready) wd_d = wd_q - 11'd1;
`endif
            end
            WAIT_DONE: begin
                err_d = err_q | m_ack_error;
                if (m_ready) begin
                    done_d    = act_oh;
                    rsp_err_d = err_q | m_ack_error;
                    rdata_d   = m_rdata;
                end
            end
            RESP:    err_d = 1'b0;
            default: ;
        endcase
    end

    assign req_ack   = req_ack_q;
    assign done      = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_en      = m_en_q;
    assign m_rw      = m_rw_q;
    assign m_addr    = m_addr_q;
    assign m_nbytes  = m_nbytes_q;
    assign m_wdata   = m_wdata_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: behavioural I2C master plus a round-robin reference model.
// The stuck-master watchdog step runs only when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_req_arbiter;
    localparam int NREQ = 4;
    localparam int MB   = 10;
    localparam int DW   = 80;
    localparam int TO   = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_rw, req_ack, done;
    logic [NREQ*7-1:0] req_addr;
    logic [NREQ*10-1:0] req_nbytes;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata, m_wdata, m_rdata;
    logic              rsp_err, m_en, m_rw, m_ready, m_ack_error;
    logic [6:0]        m_addr;
    logic [9:0]        m_nbytes;

    i2c_req_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_nbytes(req_nbytes), .req_wdata(req_wdata),
        .req_ack(req_ack), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr), .m_nbytes(m_nbytes), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_ack_error(m_ack_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural master: drops ready the cycle it sees en, stays busy busy_len cycles.
    int            busy_len = 5;
    bit            nack = 1'b0;
    bit            stuck = 1'b0;
    logic [DW-1:0] rd_val = '0;
    int            cnt = 0;
    int            rise_cyc = -1;
    int            en_cyc = -1;
    int            en_cnt = 0;
    logic [6:0]    en_addr;
    logic [9:0]    en_nb;
    logic          en_rw;
    logic [DW-1:0] en_wdata;
    logic          prev_en = 1'b0;

    always @(negedge clk) begin
        if (m_en === 1'b1) begin
            n_tests++;
            assert (prev_en === 1'b0) else begin
                n_fail++;
                $error("FAIL m_en_back_to_back observed=%b expected=0", prev_en);
            end
            en_cnt++;
            en_cyc   = cyc;
            en_addr  = m_addr;
            en_nb    = m_nbytes;
            en_rw    = m_rw;
            en_wdata = m_wdata;
        end
        prev_en = m_en;
        if (cnt > 0) begin
            cnt--;
            m_ack_error = nack && (cnt == 2);
            if (cnt == 0) begin
                m_ready  = 1'b1;
                m_rdata  = rd_val;
                rise_cyc = cyc;
            end
        end else if (m_en === 1'b1 && !stuck) begin
            cnt         = busy_len;
            m_ready     = 1'b0;
            m_ack_error = 1'b0;
        end
    end

    // Reference model state
    int            rr_m = 0;
    logic [DW-1:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] rand80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic set_port(input int p, input bit rw, input logic [6:0] a,
                            input logic [9:0] nb, input logic [DW-1:0] wd);
        req_rw[p]             = rw;
        req_addr[p*7 +: 7]    = a;
        req_nbytes[p*10 +: 10] = nb;
        req_wdata[p*DW +: DW] = wd;
    endtask

    task automatic wait_done(output int dc);
        int k;
        k = 0;
        while (done === '0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        dc = cyc;
    endtask

    task automatic do_txn(input int p, input bit rw, input logic [6:0] a,
                          input logic [9:0] nb, input logic [DW-1:0] wd);
        logic [NREQ-1:0] oh;
        bit lbad;
        int ack_c, en0, dc;
        oh = '0;
        oh[p] = 1'b1;
        lbad = (nb == 0) || (nb > MB);
        set_port(p, rw, a, nb, wd);
        en0 = en_cnt;
        req_valid = oh;
        @(negedge clk);
        ack_c = cyc;
        chk("req_ack", DW'(req_ack), DW'(oh));
        req_valid = '0;
        rr_m = (p + 1) % NREQ;
        wait_done(dc);
        chk("done_port", DW'(done), DW'(oh));
        chk("rsp_err", DW'(rsp_err), DW'(lbad || nack));
        chk("m_addr_held", DW'(m_addr), DW'(a));
        chk("m_nbytes_held", DW'(m_nbytes), DW'(nb));
        if (lbad) begin
            chk("len_err_no_m_en", DW'(en_cnt - en0), DW'(0));
            chk("len_err_done_lat", DW'(dc - ack_c), DW'(0));
        end else begin
            exp_rdata = rd_val;
            chk("m_en_count", DW'(en_cnt - en0), DW'(1));
            chk("m_en_lat", DW'(en_cyc - ack_c), DW'(1));
            chk("en_addr", DW'(en_addr), DW'(a));
            chk("en_nbytes", DW'(en_nb), DW'(nb));
            chk("en_rw", DW'(en_rw), DW'(rw));
            chk("en_wdata", en_wdata, wd);
            chk("done_lat", DW'(dc - rise_cyc), DW'(1));
        end
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        @(negedge clk);
        chk("done_one_cycle", DW'(done), DW'(0));
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    logic [NREQ-1:0] mask, oh;
    int w, g, k, dc, seen;

    initial begin
        reset = 1'b1;
        req_valid = '0; req_rw = '0; req_addr = '0; req_nbytes = '0; req_wdata = '0;
        m_ready = 1'b1; m_ack_error = 1'b0; m_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ack", DW'(req_ack), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_m_en", DW'(m_en), DW'(0));
        chk("rst_m_addr", DW'(m_addr), DW'(0));
        chk("rst_m_nbytes", DW'(m_nbytes), DW'(0));
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_rsp_err", DW'(rsp_err), DW'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single write, slow master
        busy_len = 40;
        rd_val = rand80();
        do_txn(0, 1'b0, 7'h50, 10'd2, {rand80() & ~80'hFFFF} | 80'h3CA5);
        // Read on port 2
        busy_len = 6;
        rd_val = {rand80() & ~80'hFF} | 80'h7E;
        do_txn(2, 1'b1, 7'h21, 10'd1, rand80());
        chk("read_byte0", DW'(rsp_rdata[7:0]), DW'(8'h7E));
        // Length errors
        do_txn(1, 1'b0, 7'h11, 10'd0, rand80());
        do_txn(3, 1'b1, 7'h12, 10'd11, rand80());
        do_txn(2, 1'b0, 7'h13, 10'd10, rand80());
        // NACK
        nack = 1'b1;
        busy_len = 8;
        rd_val = rand80();
        do_txn(1, 1'b0, 7'h2A, 10'd3, rand80());
        nack = 1'b0;
        // Randomized single-port transactions
        for (int i = 0; i < 8; i++) begin
            busy_len = $urandom_range(4, 20);
            rd_val = rand80();
            nack = ($urandom_range(0, 3) == 0);
            do_txn($urandom_range(0, NREQ - 1), 1'($urandom), 7'($urandom),
                   10'($urandom_range(0, 12)), rand80());
        end
        nack = 1'b0;

`ifdef I2C_ARB_TIMEOUT_EN
        stuck = 1'b1;
        set_port(3, 1'b0, 7'h33, 10'd4, rand80());
        req_valid = 4'b1000;
        @(negedge clk);
        chk("to_ack", DW'(req_ack), DW'(4'b1000));
        req_valid = '0;
        rr_m = 0;
        wait_done(dc);
        chk("to_done", DW'(done), DW'(4'b1000));
        chk("to_err", DW'(rsp_err), DW'(1));
        chk("to_latency", DW'(dc - en_cyc), DW'(TO + 1));
        chk("to_rdata_kept", rsp_rdata, exp_rdata);
        @(negedge clk);
        stuck = 1'b0;
`endif

        // Reset in WAIT_DONE
        busy_len = 50;
        set_port(1, 1'b1, 7'h44, 10'd5, rand80());
        g = en_cnt;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("rst_case_ack", DW'(req_ack), DW'(4'b0010));
        req_valid = '0;
        k = 0;
        while (en_cnt == g && k < 100) begin @(negedge clk); k++; end
        chk("rst_case_m_en_seen", DW'(en_cnt - g), DW'(1));
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_done", DW'(done), DW'(0));
        chk("midrst_m_en", DW'(m_en), DW'(0));
        chk("midrst_m_rw", DW'(m_rw), DW'(0));
        chk("midrst_m_addr", DW'(m_addr), DW'(0));
        chk("midrst_m_nbytes", DW'(m_nbytes), DW'(0));
        chk("midrst_m_wdata", m_wdata, '0);
        chk("midrst_rsp_rdata", rsp_rdata, '0);
        chk("midrst_rsp_err", DW'(rsp_err), DW'(0));
        rr_m = 0;
        exp_rdata = '0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done !== '0) seen++;
        end
        chk("midrst_no_late_done", DW'(seen), DW'(0));

        // Round robin with all ports requesting continuously
        busy_len = 4;
        rd_val = rand80();
        for (int p = 0; p < NREQ; p++)
            set_port(p, 1'($urandom), 7'($urandom), 10'($urandom_range(1, MB)), rand80());
        req_valid = '1;
        g = 0;
        k = 0;
        while (g < 5 && k < 2000) begin
            @(negedge clk);
            k++;
            if (req_ack !== '0) begin
                oh = '0;
                oh[rr_m] = 1'b1;
                chk("rr_grant", DW'(req_ack), DW'(oh));
                rr_m = (rr_m + 1) % NREQ;
                g++;
                if (g == 5) req_valid = '0;
            end
        end
        chk("rr_grant_count", DW'(g), DW'(5));
        wait_done(dc);
        chk("rr_last_done", DW'(done), DW'(4'b0001));
        exp_rdata = rd_val;
        chk("rr_rdata", rsp_rdata, exp_rdata);
        @(negedge clk);

        // Random simultaneous request sets
        for (int i = 0; i < 8; i++) begin
            busy_len = $urandom_range(4, 12);
            rd_val = rand80();
            for (int p = 0; p < NREQ; p++)
                set_port(p, 1'($urandom), 7'($urandom), 10'($urandom_range(1, MB)), rand80());
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            w = rr_pick(mask, rr_m);
            oh = '0;
            oh[w] = 1'b1;
            req_valid = mask;
            @(negedge clk);
            chk("multi_grant", DW'(req_ack), DW'(oh));
            req_valid = '0;
            rr_m = (w + 1) % NREQ;
            wait_done(dc);
            chk("multi_done", DW'(done), DW'(oh));
            chk("multi_err", DW'(rsp_err), DW'(0));
            exp_rdata = rd_val;
            chk("multi_rdata", rsp_rdata, exp_rdata);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
